// File: rtl/sha3_ctrl_pkg.sv
// Purpose: shared types, constants and helpers for the SHA3-256 absorb controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha3_ctrl_pkg;

    typedef enum logic [2:0] {
        ABSORB    = 3'd0,
        PAD       = 3'd1,
        PERMUTE   = 3'd2,
        WAIT_PERM = 3'd3,
        DONE      = 3'd4
    } ctrl_state_e;

    // Plain-vector views of the states, used by the FSM register.
    localparam logic [2:0] ST_ABSORB    = ABSORB;
    localparam logic [2:0] ST_PAD       = PAD;
    localparam logic [2:0] ST_PERMUTE   = PERMUTE;
    localparam logic [2:0] ST_WAIT_PERM = WAIT_PERM;
    localparam logic [2:0] ST_DONE      = DONE;

    localparam logic [7:0] SHA3_DOMAIN   = 8'h06;
    localparam logic [7:0] SHA3_PAD_END  = 8'h80;
    localparam int         RATE_BITS_256 = 1088;
    localparam int         WORDS_256     = 68;

    // Valid-byte count of a final beat. 2'b10 is not a legal keep pattern
    // and is treated as a full word.
    function automatic logic [1:0] keep_to_nbytes(input logic [1:0] keep);
        logic [1:0] n;
        case (keep)
            2'b00:   n = 2'd0;
            2'b01:   n = 2'd1;
            default: n = 2'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sha3_pad_gen.sv
// Purpose: builds one padded 16-bit rate word (byte mask, 0x06 domain byte, 0x80 end bit).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: word (raw data), nbytes (valid bytes 0..2), is_last_word_of_rate
// (OR 0x80 into byte1), add_domain (place 0x06 in the first unused byte),
// padded (result).
module sha3_pad_gen
    import sha3_ctrl_pkg::*;
(
    input  logic [15:0] word,
    input  logic [1:0]  nbytes,
    input  logic        is_last_word_of_rate,
    input  logic        add_domain,
    output logic [15:0] padded
);

    always_comb begin
        padded = 16'h0000;
        if (nbytes >= 2'd1) padded[7:0]  = word[7:0];
        if (nbytes >= 2'd2) padded[15:8] = word[15:8];
        // The domain byte lands right after the last message byte; a full
        // word has no room, so the caller carries it into the next word.
        if (add_domain) begin
            if (nbytes == 2'd0)      padded[7:0]  = padded[7:0]  | SHA3_DOMAIN;
            else if (nbytes == 2'd1) padded[15:8] = padded[15:8] | SHA3_DOMAIN;
        end
        if (is_last_word_of_rate) padded[15:8] = padded[15:8] | SHA3_PAD_END;
    end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// Purpose: packs a 16-bit message stream into SHA3-256 rate blocks, pads, and sequences the Keccak core.
// Latency: stream word written to the core the same cycle it is accepted; one start cycle per block.
// Backpressure: s_tready low during PAD/PERMUTE/WAIT_PERM/DONE; hash_valid held until hash_ready.
// Ports: ACLK/ARESETn; s_t* message stream in; absorb_we/addr/data state XOR port,
// perm_start/perm_done core handshake, state_clr core clear; hash_valid/hash_ready
// digest handshake; busy message in progress.
// Optional: define SHA3_CTRL_PERF_CNT_EN to add perm_cnt and msg_bytes counters.
module sha3_absorb_ctrl
    import sha3_ctrl_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RATE_BITS = RATE_BITS_256
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [DATA_W-1:0]                 s_tdata,
    input  logic [1:0]                        s_tkeep,
    input  logic                              s_tlast,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    output logic                              absorb_we,
    output logic [$clog2(RATE_BITS/DATA_W)-1:0] absorb_addr,
    output logic [DATA_W-1:0]                 absorb_data,
    output logic                              perm_start,
    input  logic                              perm_done,
    output logic                              state_clr,
    output logic                              hash_valid,
    input  logic                              hash_ready,
    output logic                              busy
`ifdef SHA3_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]                       perm_cnt,
    output logic [31:0]                       msg_bytes
`endif
);

    localparam int WORDS = RATE_BITS / DATA_W;
    localparam int AW    = $clog2(WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          final_q, final_d;
    logic          pad06_q, pad06_d;
    logic          busy_q, busy_d;
    // Holds s_tready low while ARESETn is asserted so every output reads 0
    // during reset; rises on the first clock after release.
    logic          live_q;

    logic          hs;
    logic          at_end;
    logic [1:0]    in_nbytes;

    logic [15:0]   pg_word;
    logic [1:0]    pg_nbytes;
    logic          pg_last;
    logic          pg_dom;
    logic [15:0]   pg_out;

    assign s_tready   = live_q && (state_q == ST_ABSORB);
    assign hs         = s_tready && s_tvalid;
    assign at_end     = (cnt_q == LAST_IDX);
    assign in_nbytes  = s_tlast ? keep_to_nbytes(s_tkeep) : 2'd2;

    // The pad generator serves both the stream's final beat and PAD fill words.
    always_comb begin
        pg_word   = 16'h0000;
        pg_nbytes = 2'd0;
        pg_last   = 1'b0;
        pg_dom    = 1'b0;
        if (state_q == ST_PAD) begin
            pg_dom  = pad06_q;
            pg_last = at_end;
        end else begin
            pg_word   = s_tdata;
            pg_nbytes = in_nbytes;
            pg_dom    = s_tlast;
            // A full final beat in the last slot leaves no room for padding;
            // the 0x80 then goes into an extra block.
            pg_last   = s_tlast && (in_nbytes < 2'd2) && at_end;
        end
    end

    sha3_pad_gen u_pad_gen (
        .word                 (pg_word),
        .nbytes               (pg_nbytes),
        .is_last_word_of_rate (pg_last),
        .add_domain           (pg_dom),
        .padded               (pg_out)
    );

    assign absorb_we   = hs || (state_q == ST_PAD);
    assign absorb_addr = absorb_we ? cnt_q : '0;
    assign absorb_data = absorb_we ? pg_out : '0;
    assign perm_start  = (state_q == ST_PERMUTE);
    assign hash_valid  = (state_q == ST_DONE);
    assign state_clr   = hash_valid && hash_ready;
    assign busy        = busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        final_d = final_q;
        pad06_d = pad06_q;
        busy_d  = busy_q;
        case (state_q)
            ST_ABSORB: begin
                if (hs) begin
                    busy_d = 1'b1;
                    if (!s_tlast) begin
                        if (at_end) begin
                            state_d = ST_PERMUTE;
                            final_d = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end else if (in_nbytes < 2'd2) begin
                        // Domain byte already placed in this word.
                        pad06_d = 1'b0;
                        if (at_end) begin
                            state_d = ST_PERMUTE;
                            final_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_PAD;
                            cnt_d   = cnt_q + AW'(1);
                        end
                    end else begin
                        // Full final word: the 0x06 goes into the next word,
                        // which may be in a fresh block.
                        pad06_d = 1'b1;
                        if (at_end) begin
                            state_d = ST_PERMUTE;
                            final_d = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_PAD;
                            cnt_d   = cnt_q + AW'(1);
                        end
                    end
                end
            end
            ST_PAD: begin
                pad06_d = 1'b0;
                if (at_end) begin
                    state_d = ST_PERMUTE;
                    final_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_PERMUTE: begin
                state_d = ST_WAIT_PERM;
            end
            ST_WAIT_PERM: begin
                if (perm_done) begin
                    if (final_q)      state_d = ST_DONE;
                    else if (pad06_q) state_d = ST_PAD;
                    else              state_d = ST_ABSORB;
                end
            end
            ST_DONE: begin
                if (hash_ready) begin
                    state_d = ST_ABSORB;
                    cnt_d   = '0;
                    final_d = 1'b0;
                    pad06_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_ABSORB;
                cnt_d   = '0;
                final_d = 1'b0;
                pad06_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_ABSORB;
            cnt_q   <= '0;
            final_q <= 1'b0;
            pad06_q <= 1'b0;
            busy_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            final_q <= final_d;
            pad06_q <= pad06_d;
            busy_q  <= busy_d;
            live_q  <= 1'b1;
        end
    end

`ifdef SHA3_CTRL_PERF_CNT_EN
    logic [15:0] perm_cnt_q, perm_cnt_d;
    logic [31:0] msg_bytes_q, msg_bytes_d;

    always_comb begin
        perm_cnt_d  = perm_cnt_q;
        msg_bytes_d = msg_bytes_q;
        if (state_clr) begin
            perm_cnt_d  = 16'h0000;
            msg_bytes_d = 32'h0000_0000;
        end else begin
            if (perm_start && (perm_cnt_q != 16'hFFFF)) perm_cnt_d = perm_cnt_q + 16'd1;
            if (hs) msg_bytes_d = msg_bytes_q + 32'(in_nbytes);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            perm_cnt_q  <= 16'h0000;
            msg_bytes_q <= 32'h0000_0000;
        end else begin
            perm_cnt_q  <= perm_cnt_d;
            msg_bytes_q <= msg_bytes_d;
        end
    end

    assign perm_cnt  = perm_cnt_q;
    assign msg_bytes = msg_bytes_q;
`endif

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Purpose: directed self-checking bench for sha3_absorb_ctrl (default build).
// Latency: n/a.
// Backpressure: exercised via gapped s_tvalid, delayed perm_done and late hash_ready.
module tb_sha3_absorb_ctrl;

    logic        ACLK;
    logic        ARESETn;
    logic [15:0] s_tdata;
    logic [1:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic        absorb_we;
    logic [6:0]  absorb_addr;
    logic [15:0] absorb_data;
    logic        perm_start;
    logic        perm_done;
    logic        state_clr;
    logic        hash_valid;
    logic        hash_ready;
    logic        busy;

    sha3_absorb_ctrl dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .absorb_we   (absorb_we),
        .absorb_addr (absorb_addr),
        .absorb_data (absorb_data),
        .perm_start  (perm_start),
        .perm_done   (perm_done),
        .state_clr   (state_clr),
        .hash_valid  (hash_valid),
        .hash_ready  (hash_ready),
        .busy        (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;
    int perm_lat = 3;

    // Observation log, filled at falling edges.
    logic [6:0]  log_a[$];
    logic [15:0] log_d[$];
    int          perm_starts = 0;
    int          clr_pulses  = 0;
    int          rdy_bad     = 0;
    logic        in_perm     = 1'b0;

    // Hand-written expected write sequence for the current message.
    logic [6:0]  exp_a[$];
    logic [15:0] exp_d[$];

    logic        hs_we;
    logic [6:0]  hs_addr;
    logic [15:0] hs_dat;

    always @(negedge ACLK) begin
        if (absorb_we) begin
            log_a.push_back(absorb_addr);
            log_d.push_back(absorb_data);
            if (!s_tvalid && s_tready) rdy_bad++;
        end
        if (perm_start) begin
            perm_starts++;
            in_perm = 1'b1;
        end
        if (perm_done || !ARESETn) in_perm = 1'b0;
        if (in_perm && s_tready) rdy_bad++;
        if (state_clr) clr_pulses++;
    end

    // Keccak core stand-in: perm_done one cycle, perm_lat cycles after start.
    initial begin
        perm_done = 1'b0;
        forever begin
            @(negedge ACLK);
            if (perm_start) begin
                repeat (perm_lat) @(posedge ACLK);
                #2 perm_done = 1'b1;
                @(posedge ACLK);
                #2 perm_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag, input int waited);
        checks++;
        errors++;
        $display("FAIL %s: waited %0d cycles without the event, required it within the limit", tag, waited);
    endtask

    task automatic exp_push(input int a, input logic [15:0] d);
        exp_a.push_back(7'(a));
        exp_d.push_back(d);
    endtask

    task automatic exp_zeros(input int from, input int to);
        for (int a = from; a <= to; a++) exp_push(a, 16'h0000);
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        exp_a.delete();
        exp_d.delete();
        perm_starts = 0;
        clr_pulses  = 0;
        rdy_bad     = 0;
    endtask

    // Called at posedge+2; returns at posedge+2 after the handshake edge.
    task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
        int t;
        t = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge ACLK);
        while (!s_tready && t < 300) begin
            @(negedge ACLK);
            t++;
        end
        if (t >= 300) timeout_fail("beat_accept", t);
        hs_we   = absorb_we;
        hs_addr = absorb_addr;
        hs_dat  = absorb_data;
        @(posedge ACLK);
        #2;
        s_tvalid = 1'b0;
    endtask

    task automatic finish_hash(input int hold);
        int t;
        t = 0;
        @(negedge ACLK);
        while (!hash_valid && t < 500) begin
            @(negedge ACLK);
            t++;
        end
        if (t >= 500) timeout_fail("hash_valid_wait", t);
        chk("busy_before_clr", 32'(busy), 32'd1);
        repeat (hold) @(negedge ACLK);
        chk("hash_valid_held", 32'(hash_valid), 32'd1);
        chk("no_clr_before_ready", 32'(clr_pulses), 32'd0);
        @(posedge ACLK);
        #2 hash_ready = 1'b1;
        #3;
        chk("state_clr_on_ready", 32'(state_clr), 32'd1);
        @(posedge ACLK);
        #2 hash_ready = 1'b0;
        #3;
        chk("busy_after_clr", 32'(busy), 32'd0);
        chk("hash_valid_after_clr", 32'(hash_valid), 32'd0);
        @(posedge ACLK);
        #2;
    endtask

    task automatic check_log(input string tag, input int exp_starts);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = -1;
        chk({tag, "_nwrites"}, 32'(log_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
            if (log_a[i] !== exp_a[i] || log_d[i] !== exp_d[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (bad != 0)
            $display("note %s: first differing write #%0d addr=%0d data=%h wanted addr=%0d data=%h",
                     tag, first_bad, log_a[first_bad], log_d[first_bad], exp_a[first_bad], exp_d[first_bad]);
        chk({tag, "_bad_words"}, 32'(bad), 32'd0);
        chk({tag, "_perm_starts"}, 32'(perm_starts), 32'(exp_starts));
        chk({tag, "_clr_pulses"}, 32'(clr_pulses), 32'd1);
        chk({tag, "_rdy_while_busy"}, 32'(rdy_bad), 32'd0);
    endtask

    task automatic run_empty(input string tag);
        clear_log();
        exp_push(0, 16'h0006);
        exp_zeros(1, 66);
        exp_push(67, 16'h8000);
        // Data bits must be masked out by keep=00.
        send_beat(16'h1234, 2'b00, 1'b1);
        chk({tag, "_hs_we"}, 32'(hs_we), 32'd1);
        chk({tag, "_hs_addr"}, 32'(hs_addr), 32'd0);
        chk({tag, "_hs_data"}, 32'(hs_dat), 32'h0006);
        finish_hash(0);
        check_log(tag, 1);
    endtask

    initial begin
        ARESETn    = 1'b0;
        s_tdata    = 16'hFFFF;
        s_tkeep    = 2'b00;
        s_tlast    = 1'b1;
        s_tvalid   = 1'b1;
        hash_ready = 1'b1;

        // Reset: every output low even with a valid beat and hash_ready offered.
        repeat (2) @(negedge ACLK);
        chk("rst_ctrl_outputs", 32'({s_tready, absorb_we, perm_start, state_clr, hash_valid, busy}), 32'd0);
        chk("rst_addr", 32'(absorb_addr), 32'd0);
        chk("rst_data", 32'(absorb_data), 32'd0);
        @(posedge ACLK);
        #2;
        s_tvalid   = 1'b0;
        hash_ready = 1'b0;
        ARESETn    = 1'b1;
        repeat (2) @(posedge ACLK);
        #3;
        chk("ready_after_reset", 32'(s_tready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge ACLK);
        #2;

        // Empty message.
        run_empty("empty");

        // "abc"; upper byte of the final beat is junk and must be masked.
        clear_log();
        exp_push(0, 16'h6261);
        exp_push(1, 16'h0663);
        exp_zeros(2, 66);
        exp_push(67, 16'h8000);
        send_beat(16'h6261, 2'b11, 1'b0);
        send_beat(16'hFF63, 2'b01, 1'b1);
        chk("abc_last_hs_data", 32'(hs_dat), 32'h0663);
        chk("abc_last_hs_addr", 32'(hs_addr), 32'd1);
        finish_hash(0);
        check_log("abc", 1);

        // 136 bytes: full block, then an extra pure-padding block.
        clear_log();
        for (int i = 0; i < 68; i++) exp_push(i, {8'(2 * i + 1), 8'(2 * i)});
        exp_push(0, 16'h0006);
        exp_zeros(1, 66);
        exp_push(67, 16'h8000);
        for (int i = 0; i < 68; i++) send_beat({8'(2 * i + 1), 8'(2 * i)}, 2'b11, 1'(i == 67));
        chk("b136_last_hs_data", 32'(hs_dat), 32'h8786);
        finish_hash(0);
        check_log("b136", 2);

        // 135 bytes: final beat in slot 67 carries 0x86 in byte1.
        clear_log();
        for (int i = 0; i < 67; i++) exp_push(i, {8'(2 * i + 1), 8'(2 * i)});
        exp_push(67, 16'h86AB);
        for (int i = 0; i < 67; i++) send_beat({8'(2 * i + 1), 8'(2 * i)}, 2'b11, 1'b0);
        send_beat(16'h55AB, 2'b01, 1'b1);
        chk("b135_last_hs_data", 32'(hs_dat), 32'h86AB);
        finish_hash(0);
        check_log("b135", 1);

        // Gapped valid, slow core, late consumer.
        perm_lat = 30;
        clear_log();
        exp_push(0, 16'h1111);
        exp_push(1, 16'h2222);
        exp_push(2, 16'h3333);
        exp_push(3, 16'h4444);
        exp_push(4, 16'h0006);
        exp_zeros(5, 66);
        exp_push(67, 16'h8000);
        send_beat(16'h1111, 2'b11, 1'b0);
        @(posedge ACLK); #2;
        send_beat(16'h2222, 2'b11, 1'b0);
        @(posedge ACLK); #2;
        send_beat(16'h3333, 2'b11, 1'b0);
        @(posedge ACLK); #2;
        send_beat(16'h4444, 2'b11, 1'b1);
        finish_hash(10);
        check_log("bp", 1);

        // Reset while waiting on the core, then a clean empty message.
        clear_log();
        send_beat(16'h0000, 2'b00, 1'b1);
        begin
            int t;
            t = 0;
            while (perm_starts == 0 && t < 300) begin
                @(negedge ACLK);
                t++;
            end
            if (t >= 300) timeout_fail("perm_start_wait", t);
        end
        repeat (5) @(posedge ACLK);
        #2 ARESETn = 1'b0;
        #1;
        chk("mid_rst_ctrl_outputs", 32'({s_tready, absorb_we, perm_start, state_clr, hash_valid, busy}), 32'd0);
        chk("mid_rst_addr_data", 32'({absorb_addr, absorb_data}), 32'd0);
        @(posedge ACLK);
        #2 ARESETn = 1'b1;
        repeat (40) @(posedge ACLK);
        #2;
        perm_lat = 3;
        run_empty("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha3_absorb_ctrl.md
Name: sha3_absorb_ctrl

Overview:
- Sequences one SHA3-256 hash through the Keccak permutation core.
- Accepts a 16-bit AXI-Stream-style message on ACLK, packs it into rate-sized blocks, applies SHA3 padding (0x06 … 0x80) and writes the words into the core's state XOR port.
- Issues one permutation start per block, then flags digest-ready to the consumer.
- Sits between the AXI input wrapper and the Keccak round core, replacing hand-padded input words.

Parameters:
- DATA_W, 16, stream word width in bits; only 16 is supported.
- RATE_BITS, 1088, sponge rate in bits (SHA3-256).
- WORDS, RATE_BITS/DATA_W = 68, words per block (derived localparam).
- AW, $clog2(WORDS) = 7, word address width (derived).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- s_tdata  in  16  message word; byte0 = [7:0] is first in message order
- s_tkeep  in  2  valid bytes on the last word: 00 = 0, 01 = 1, 11 = 2; ignored (treated 11) when s_tlast=0
- s_tlast  in  1  final message word
- s_tvalid  in  1  word valid
- s_tready  out  1  controller can accept a word
- absorb_we  out  1  XOR absorb_data into state word absorb_addr this cycle
- absorb_addr  out  AW  word index 0..WORDS-1 within the rate
- absorb_data  out  16  word to XOR (message plus padding)
- perm_start  out  1  one-cycle pulse to start the 24-round permutation
- perm_done  in  1  one-cycle pulse from the core, permutation finished
- state_clr  out  1  one-cycle pulse to zero the core state
- hash_valid  out  1  digest in the core state is final
- hash_ready  in  1  consumer has taken the digest
- busy  out  1  message in progress (high from first accepted word until state_clr)

Behaviour:
- Reset (asynchronous, any time including mid-block or mid-permutation):
  - FSM goes to ABSORB with word counter = 0; pad flags cleared.
  - All outputs 0.
  - The core shares ARESETn, so no clear is needed.
- FSM states: ABSORB, PAD, PERMUTE, WAIT_PERM, DONE.
- ABSORB:
  - s_tready=1. On handshake: absorb_we=1, absorb_addr=cnt, absorb_data=s_tdata, same cycle (combinational from the handshake, zero latency).
  - Non-last word:
    - If cnt==WORDS-1, go to PERMUTE with final=0; cnt wraps to 0.
    - Otherwise cnt++.
  - Last word with n valid bytes. Unused bytes are masked to 0; pad bytes are generated by sha3_pad_gen.
    - n<2, cnt<WORDS-1: byte n = 0x06; go to PAD at cnt+1.
    - n<2, cnt==WORDS-1: byte n |= 0x06 and byte1 |= 0x80 (n=1 gives byte1 = 0x86; n=0 gives word 0x8006); go to PERMUTE with final=1.
    - n=2, cnt<WORDS-1: go to PAD at cnt+1 with pad06_pending=1.
    - n=2, cnt==WORDS-1: go to PERMUTE with final=0 and pad06_pending=1; after WAIT_PERM, go to PAD at word 0 (extra full pad block).
- PAD:
  - s_tready=0. Emits one word per cycle, cnt..WORDS-1.
  - Word contents: byte0 = 0x06 if pad06_pending (cleared after that word), else 0. Word WORDS-1 gets byte1 |= 0x80.
  - After word WORDS-1, go to PERMUTE with final=1.
- PERMUTE: perm_start=1 for exactly one cycle; go to WAIT_PERM.
- WAIT_PERM:
  - s_tready=0; wait for perm_done.
  - final=1 goes to DONE; final=0 goes to ABSORB, or to PAD if pad06_pending.
  - perm_done in any other state is ignored.
- DONE:
  - hash_valid=1 and held until hash_ready=1.
  - On that cycle: state_clr=1 for one cycle, busy drops, go to ABSORB with cnt=0.
- Latency:
  - Each block costs WORDS accept cycles + 1 start cycle + core latency.
  - PAD adds WORDS-1-cnt_last cycles.
- absorb_we is never asserted outside ABSORB handshakes and PAD.

Optional Feature:
- Macro SHA3_CTRL_PERF_CNT_EN.
- Defined:
  - Adds output perm_cnt (16 bits), counting perm_start pulses since the last state_clr or reset; saturates at 0xFFFF.
  - Adds output msg_bytes (32 bits), counting accepted message bytes; wraps.
  - Both are cleared on state_clr.
- Undefined: neither port exists and no counter flops are built.

Decomposition:
- sha3_ctrl_pkg holds:
  - Enum ctrl_state_e {ABSORB, PAD, PERMUTE, WAIT_PERM, DONE}.
  - Constants SHA3_DOMAIN = 8'h06, SHA3_PAD_END = 8'h80, RATE_BITS_256 = 1088, WORDS_256 = 68.
  - Function keep_to_nbytes (2 bits to a count 0..2).
- One sub-module, sha3_pad_gen (combinational):
  - Inputs: word, nbytes, is_last_word_of_rate, add_domain.
  - Output: the padded 16-bit word.
  - Used by both the ABSORB last-word path and PAD.

Test Plan:
- Empty message: one beat, tkeep=00, tlast=1, cnt=0 -> write addr0=0x0006, addr1..66=0x0000, addr67=0x8000, one perm_start, then hash_valid. With the real core, digest = a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a.
- "abc": beats 0x6261 (keep 11), 0x0063 (keep 01, last) -> addr0=0x6261, addr1=0x0663, zeros, addr67=0x8000. Digest = 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- 136-byte message (68 full beats, last on beat 67, keep 11) -> two perm_starts; second block writes addr0=0x0006, addr67=0x8000; s_tready=0 during PAD and WAIT_PERM.
- 135-byte message (last beat cnt=67, keep 01) -> addr67 = {0x86, data byte}; exactly one perm_start.
- Backpressure/handshake: s_tvalid toggling every cycle, perm_done delayed 30 cycles, hash_ready held low for 10 cycles -> no lost or duplicated writes; hash_valid stays high; state_clr pulses once on acceptance.
- Reset mid-operation: ARESETn low during WAIT_PERM -> all outputs 0 immediately; a next empty message produces the same result as the first test.
